// File: rtl/keypad_hex_entry.sv
// Scans a 4x4 active-low hex keypad, debounces and decodes presses, and shifts each
// accepted digit into a 4-digit number. Optional macro KEYPAD_CLEAR_KEY_EN: key C clears the number.
module keypad_hex_entry #(
    parameter int SCAN_DIV_BITS    = 17,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic [3:0]  row_sense,
    output logic [3:0]  col_drive,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_pressed,
    output logic [15:0] entered_number
);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    localparam logic [3:0] DEB_TARGET = 4'(DEBOUNCE_SAMPLES);

    state_t                   state_r;
    logic [3:0]               sync1_r;
    logic [3:0]               rs_r;
    logic [SCAN_DIV_BITS-1:0] dwell_r;
    logic [1:0]               col_r;
    logic [1:0]               row_r;
    logic [3:0]               cnt_r;

    logic                     sample_s;
    logic                     hit_s;
    logic [1:0]               win_row_s;
    logic [1:0]               col_next_s;
    logic [3:0]               cnt_inc_s;
    logic [3:0]               acc_code_s;

    function automatic logic [3:0] decode_key(input logic [1:0] col, input logic [1:0] row);
        logic [3:0] code;
        case ({col, row})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h4;
            4'b00_10: code = 4'h7;
            4'b00_11: code = 4'h0;
            4'b01_00: code = 4'h2;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h8;
            4'b01_11: code = 4'hF;
            4'b10_00: code = 4'h3;
            4'b10_01: code = 4'h6;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hE;
            4'b11_00: code = 4'hA;
            4'b11_01: code = 4'hB;
            4'b11_10: code = 4'hC;
            4'b11_11: code = 4'hD;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] col_low(input logic [1:0] col);
        logic [3:0] drive;
        case (col)
            2'd0:    drive = 4'b1110;
            2'd1:    drive = 4'b1101;
            2'd2:    drive = 4'b1011;
            2'd3:    drive = 4'b0111;
            default: drive = 4'b1110;
        endcase
        return drive;
    endfunction

    function automatic logic [15:0] next_number(input logic [15:0] cur, input logic [3:0] code);
        logic [15:0] nxt;
`ifdef KEYPAD_CLEAR_KEY_EN
        if (code == 4'hC) begin
            nxt = 16'h0000;
        end else begin
            nxt = {cur[11:0], code};
        end
`else
        nxt = {cur[11:0], code};
`endif
        return nxt;
    endfunction

    // Sample strobe, lowest-row priority pick and next-column helpers
    always_comb begin
        sample_s   = &dwell_r;
        hit_s      = (rs_r != 4'hF);
        col_next_s = col_r + 2'd1;
        cnt_inc_s  = cnt_r + 4'd1;
        if (!rs_r[0]) begin
            win_row_s = 2'd0;
        end else if (!rs_r[1]) begin
            win_row_s = 2'd1;
        end else if (!rs_r[2]) begin
            win_row_s = 2'd2;
        end else begin
            win_row_s = 2'd3;
        end
        acc_code_s = decode_key(col_r, win_row_s);
    end

    // Two-flop synchronizer for the asynchronous rows and the free-running dwell counter
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            sync1_r <= 4'hF;
            rs_r    <= 4'hF;
            dwell_r <= '0;
        end else begin
            sync1_r <= row_sense;
            rs_r    <= sync1_r;
            dwell_r <= dwell_r + SCAN_DIV_BITS'(1);
        end
    end

    // Scan / debounce / held state machine with registered outputs
    always_ff @(posedge clock_100Mhz or posedge reset) begin
        if (reset) begin
            state_r        <= SCAN;
            col_r          <= 2'd0;
            row_r          <= 2'd0;
            cnt_r          <= 4'd0;
            col_drive      <= 4'b1110;
            key_code       <= 4'h0;
            key_valid      <= 1'b0;
            key_pressed    <= 1'b0;
            entered_number <= 16'h0000;
        end else begin
            key_valid <= 1'b0;
            if (sample_s) begin
                case (state_r)
                    SCAN: begin
                        if (hit_s) begin
                            row_r <= win_row_s;
                            if (DEB_TARGET == 4'd1) begin
                                key_code       <= acc_code_s;
                                key_valid      <= 1'b1;
                                key_pressed    <= 1'b1;
                                entered_number <= next_number(entered_number, acc_code_s);
                                cnt_r          <= 4'd0;
                                state_r        <= HELD;
                            end else begin
                                cnt_r   <= 4'd1;
                                state_r <= DEBOUNCE;
                            end
                        end else begin
                            col_r     <= col_next_s;
                            col_drive <= col_low(col_next_s);
                        end
                    end
                    DEBOUNCE: begin
                        if (hit_s && (win_row_s == row_r)) begin
                            if (cnt_inc_s == DEB_TARGET) begin
                                key_code       <= acc_code_s;
                                key_valid      <= 1'b1;
                                key_pressed    <= 1'b1;
                                entered_number <= next_number(entered_number, acc_code_s);
                                cnt_r          <= 4'd0;
                                state_r        <= HELD;
                            end else begin
                                cnt_r <= cnt_inc_s;
                            end
                        end else begin
                            cnt_r     <= 4'd0;
                            state_r   <= SCAN;
                            col_r     <= col_next_s;
                            col_drive <= col_low(col_next_s);
                        end
                    end
                    HELD: begin
                        // Keys in other columns are invisible here since only this column is driven
                        if (rs_r == 4'hF) begin
                            if (cnt_inc_s == DEB_TARGET) begin
                                key_pressed <= 1'b0;
                                cnt_r       <= 4'd0;
                                state_r     <= SCAN;
                                col_r       <= col_next_s;
                                col_drive   <= col_low(col_next_s);
                            end else begin
                                cnt_r <= cnt_inc_s;
                            end
                        end else begin
                            cnt_r <= 4'd0;
                        end
                    end
                    default: begin
                        cnt_r     <= 4'd0;
                        state_r   <= SCAN;
                        col_r     <= 2'd0;
                        col_drive <= 4'b1110;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Bench for keypad_hex_entry: emulates a physical keypad and checks the DUT every cycle
// against a sample-level model, plus hand-computed literal expectations.
module tb_keypad_hex_entry;

    localparam int DWELL = 16;
    localparam int DS    = 2;

    logic        clock_100Mhz = 1'b0;
    logic        reset        = 1'b0;
    logic [3:0]  row_sense;
    logic [3:0]  col_drive;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_pressed;
    logic [15:0] entered_number;

    logic [15:0] pressed = 16'h0000;   // bit row*4+col set while that key is held down
    int          vectors     = 0;
    int          miscompares = 0;
    bit          checking    = 1'b0;

    logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'h0, 4'hF, 4'hE, 4'hD};

    always #5 clock_100Mhz = ~clock_100Mhz;

    keypad_hex_entry #(
        .SCAN_DIV_BITS   (4),
        .DEBOUNCE_SAMPLES(2)
    ) dut (
        .clock_100Mhz  (clock_100Mhz),
        .reset         (reset),
        .row_sense     (row_sense),
        .col_drive     (col_drive),
        .key_code      (key_code),
        .key_valid     (key_valid),
        .key_pressed   (key_pressed),
        .entered_number(entered_number)
    );

    // Physical keypad: a row reads low when a pressed key sits on a driven column
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_sense[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_drive[c]) row_sense[r] = 1'b0;
            end
        end
    end

    // ---------------- reference model ----------------
    int          m_dwell, m_col, m_cand, m_streak, m_rel;
    bit          m_held, m_valid, m_pressed;
    logic [3:0]  m_s1, m_s2, m_code;
    logic [15:0] m_num;

    function automatic logic [3:0] rows_for(input int col);
        logic [3:0] rows;
        for (int r = 0; r < 4; r++) rows[r] = !pressed[r*4+col];
        return rows;
    endfunction

    function automatic logic [15:0] key_bit(input int r, input int c);
        logic [15:0] one = 16'h0001;
        return one << (r*4 + c);
    endfunction

    task automatic model_reset();
        m_dwell = 0; m_col = 0; m_cand = -1; m_streak = 0; m_rel = 0;
        m_held = 0; m_valid = 0; m_pressed = 0;
        m_s1 = 4'hF; m_s2 = 4'hF; m_code = 4'h0; m_num = 16'h0000;
    endtask

    task automatic model_accept(input int row);
        m_code    = keymap[row*4 + m_col];
        m_valid   = 1;
        m_pressed = 1;
        m_held    = 1;
        m_cand    = -1;
        m_rel     = 0;
`ifdef KEYPAD_CLEAR_KEY_EN
        if (m_code == 4'hC) m_num = 16'h0000;
        else m_num = {m_num[11:0], m_code};
`else
        m_num = {m_num[11:0], m_code};
`endif
    endtask

    task automatic model_step();
        logic [3:0] seen;
        int key;
        bit smp;
        seen    = m_s2;
        smp     = (m_dwell == DWELL - 1);
        m_s2    = m_s1;
        m_s1    = rows_for(m_col);
        m_dwell = (m_dwell + 1) % DWELL;
        m_valid = 0;
        if (smp) begin
            key = -1;
            for (int r = 3; r >= 0; r--) if (!seen[r]) key = r;
            if (m_held) begin
                m_rel = (seen == 4'hF) ? m_rel + 1 : 0;
                if (m_rel == DS) begin
                    m_held = 0; m_pressed = 0; m_rel = 0; m_col = (m_col + 1) % 4;
                end
            end else if (m_cand < 0) begin
                if (key < 0) m_col = (m_col + 1) % 4;
                else begin
                    m_cand = key; m_streak = 1;
                    if (m_streak == DS) model_accept(key);
                end
            end else if (key == m_cand) begin
                m_streak++;
                if (m_streak == DS) model_accept(key);
            end else begin
                m_cand = -1; m_col = (m_col + 1) % 4;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock_100Mhz or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    // Per-cycle comparison against the model
    initial begin
        logic [3:0] one = 4'b0001;
        logic [3:0] exp_col;
        forever begin
            @(negedge clock_100Mhz);
            if (checking && !reset) begin
                exp_col = ~(one << m_col);
                vectors++;
                if (col_drive !== exp_col || key_code !== m_code || key_valid !== m_valid ||
                    key_pressed !== m_pressed || entered_number !== m_num) begin
                    miscompares++;
                    $display("FAIL cycle_compare t=%0t got col=%b code=%h valid=%b pressed=%b num=%h expected col=%b code=%h valid=%b pressed=%b num=%h",
                             $time, col_drive, key_code, key_valid, key_pressed, entered_number,
                             exp_col, m_code, m_valid, m_pressed, m_num);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock_100Mhz);
        reset = 1'b1;
        @(negedge clock_100Mhz);
        reset = 1'b0;
    endtask

    task automatic release_all(input string name);
        bit done;
        pressed = 16'h0000;
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock_100Mhz);
            if (!key_pressed) done = 1;
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL %s_release: key_pressed got 1 expected 0 after bound", name);
        end
        repeat (3) @(negedge clock_100Mhz);
    endtask

    task automatic enter_key(input logic [15:0] keys, input logic [3:0] exp_code,
                             input logic [15:0] exp_num, input bit rel, input string name);
        bit ok;
        pressed = keys;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock_100Mhz);
            if (key_valid) ok = 1;
        end
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL %s_valid: key_valid got 0 expected 1 within bound", name);
        end else begin
            check({name, "_code"}, key_code, exp_code);
            check({name, "_num"}, entered_number, exp_num);
            check({name, "_pressed"}, key_pressed, 1'b1);
        end
        if (rel) release_all(name);
    endtask

    task automatic wait_dwell_start();
        for (int i = 0; i < 40 && m_dwell != 0; i++) @(negedge clock_100Mhz);
    endtask

    initial begin
        logic [3:0] steps [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        int pulses;
        int drops;
        int col_bad;

        #1 reset = 1'b1;
        checking = 1'b1;
        repeat (3) @(negedge clock_100Mhz);
        reset = 1'b0;

        // 1: column stepping from reset
        repeat (8) @(negedge clock_100Mhz);
        check("step0", col_drive, steps[0]);
        for (int i = 1; i < 5; i++) begin
            repeat (16) @(negedge clock_100Mhz);
            check($sformatf("step%0d", i), col_drive, steps[i]);
        end

        // 2: key 5 held, single pulse, column held
        enter_key(key_bit(1, 1), 4'h5, 16'h0005, 1'b0, "key5");
        pulses = 0; col_bad = 0;
        repeat (64) begin
            @(negedge clock_100Mhz);
            if (key_valid) pulses++;
            if (col_drive !== 4'b1101) col_bad++;
        end
        check("key5_no_repeat", 16'(pulses), 16'd0);
        check("key5_col_held", 16'(col_bad), 16'd0);

        // 1b: asynchronous reset mid-operation
        @(negedge clock_100Mhz);
        #2 reset = 1'b1;
        #1;
        check("rst_col", col_drive, 4'b1110);
        check("rst_num", entered_number, 16'h0000);
        check("rst_valid", key_valid, 1'b0);
        check("rst_pressed", key_pressed, 1'b0);
        pressed = 16'h0000;
        @(negedge clock_100Mhz);
        reset = 1'b0;
        repeat (4) @(negedge clock_100Mhz);

        // 3: digit sequence
        enter_key(key_bit(0, 0), 4'h1, 16'h0001, 1'b1, "seq1");
        enter_key(key_bit(0, 1), 4'h2, 16'h0012, 1'b1, "seq2");
        enter_key(key_bit(0, 2), 4'h3, 16'h0123, 1'b1, "seq3");
        enter_key(key_bit(0, 3), 4'hA, 16'h123A, 1'b1, "seqA");
        enter_key(key_bit(1, 0), 4'h4, 16'h23A4, 1'b1, "seq4");

        // 4a: one-sample bounce on whichever column is being scanned
        wait_dwell_start();
        pressed = key_bit(2, m_col);
        pulses = 0;
        repeat (16) begin
            @(negedge clock_100Mhz);
            if (key_valid) pulses++;
        end
        pressed = 16'h0000;
        repeat (48) begin
            @(negedge clock_100Mhz);
            if (key_valid) pulses++;
        end
        check("bounce_no_valid", 16'(pulses), 16'd0);

        // 4b: one-sample release glitch while held
        enter_key(key_bit(2, 0), 4'h7, 16'h3A47, 1'b0, "glitch7");
        wait_dwell_start();
        pressed = 16'h0000;
        repeat (16) @(negedge clock_100Mhz);
        pressed = key_bit(2, 0);
        pulses = 0; drops = 0;
        repeat (64) begin
            @(negedge clock_100Mhz);
            if (key_valid) pulses++;
            if (!key_pressed) drops++;
        end
        check("glitch_no_valid", 16'(pulses), 16'd0);
        check("glitch_held", 16'(drops), 16'd0);
        release_all("glitch7");

        // 5: rows 0 and 2 on column 2
        enter_key(key_bit(0, 2) | key_bit(2, 2), 4'h3, 16'hA473, 1'b1, "multirow");

        // 6: clear key
        do_reset();
        repeat (4) @(negedge clock_100Mhz);
        enter_key(key_bit(0, 0), 4'h1, 16'h0001, 1'b1, "pre1");
        enter_key(key_bit(0, 1), 4'h2, 16'h0012, 1'b1, "pre2");
        enter_key(key_bit(0, 2), 4'h3, 16'h0123, 1'b1, "pre3");
        enter_key(key_bit(1, 0), 4'h4, 16'h1234, 1'b1, "pre4");
`ifdef KEYPAD_CLEAR_KEY_EN
        enter_key(key_bit(2, 3), 4'hC, 16'h0000, 1'b1, "keyC");
`else
        enter_key(key_bit(2, 3), 4'hC, 16'h234C, 1'b1, "keyC");
`endif

        repeat (8) @(negedge clock_100Mhz);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
